// File: rtl/prbs_ctrl_pkg.sv
// Shared types and widths for the PRBS run sequencer and its helpers.
package prbs_ctrl_pkg;

    localparam int PRBS_WORD_W = 32;
    localparam int PRBS_N_W    = 8;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;

    // Result of the last run; at most one bit is ever set.
    typedef struct packed {
        logic pass;
        logic timed_out;
        logic aborted;
        logic err_cfg;
    } seq_status_t;

endpackage

// File: rtl/prbs_run_counter.sv
// RUN-cycle counter: clear, enable, saturate at all-ones, terminal-count flag.
// run_cnt_o is the count of the cycle in progress (register + 1), so the
// first enabled cycle after a clear already reads 1.
module prbs_run_counter #(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] run_cnt_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;

    // Saturating increment; never wraps back to zero.
    always_comb begin
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next count: clear has priority over enable.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_inc;
    end

    // Count register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign run_cnt_o = cnt_inc;
    assign tc_o      = (cnt_inc == TC_VAL);

endmodule

// File: rtl/prbs_test_sequencer.sv
// Sequences one PRBS generate/detect run: load strobe to the wrapper, wait for
// detect / timeout / abort, then report a sticky status and the RUN latency.
module prbs_test_sequencer
    import prbs_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   start,
    input  logic [PRBS_WORD_W-1:0] cfg_word,
    input  logic [PRBS_N_W-1:0]    cfg_n,
    input  logic                   abort,
    output logic                   prbs_data_valid,
    output logic [PRBS_WORD_W-1:0] prbs_in,
    output logic [PRBS_N_W-1:0]    prbs_n,
    input  logic                   pattern_detected,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timed_out,
    output logic                   aborted,
    output logic                   err_cfg,
    output logic [CNT_W-1:0]       latency
);

    seq_state_t             state_q, state_d;
    seq_status_t            stat_q, stat_d;
    logic [CNT_W-1:0]       lat_q, lat_d;
    logic [PRBS_WORD_W-1:0] word_q, word_d;
    logic [PRBS_N_W-1:0]    n_q, n_d;
    logic [CNT_W-1:0]       run_cnt;
    logic                   cnt_clr, cnt_en, cnt_tc;

    prbs_run_counter #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .run_cnt_o (run_cnt),
        .tc_o      (cnt_tc)
    );

    // Next state, captured config, status and latency.
    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        lat_d   = lat_q;
        word_d  = word_q;
        n_d     = n_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    stat_d = '0;
                    lat_d  = '0;
                    if (cfg_n != '0) begin
                        state_d = LOAD;
                        word_d  = cfg_word;
                        n_d     = cfg_n;
                    end else begin
                        // Zero repeat count: report and skip the wrapper entirely.
                        state_d        = DONE;
                        stat_d.err_cfg = 1'b1;
                    end
                end
            end
            LOAD: begin
                // The strobe is driven this cycle regardless of abort.
                cnt_clr = 1'b1;
                state_d = RUN;
                if (abort) begin
                    state_d        = DONE;
                    stat_d.aborted = 1'b1;
                    lat_d          = '0;
                end
            end
            RUN: begin
                cnt_en = 1'b1;
                if (abort) begin
                    state_d        = DONE;
                    stat_d.aborted = 1'b1;
                    lat_d          = run_cnt;
                end else if (pattern_detected) begin
                    state_d     = DONE;
                    stat_d.pass = 1'b1;
                    lat_d       = run_cnt;
                end else if (cnt_tc) begin
                    state_d          = DONE;
                    stat_d.timed_out = 1'b1;
                    lat_d            = run_cnt;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            stat_q  <= '0;
            lat_q   <= '0;
            word_q  <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            stat_q  <= stat_d;
            lat_q   <= lat_d;
            word_q  <= word_d;
            n_q     <= n_d;
        end
    end

    assign prbs_data_valid = (state_q == LOAD);
    assign prbs_in         = word_q;
    assign prbs_n          = n_q;
    assign busy            = (state_q == LOAD) || (state_q == RUN);
    assign done            = (state_q == DONE);
    assign pass            = stat_q.pass;
    assign timed_out       = stat_q.timed_out;
    assign aborted         = stat_q.aborted;
    assign err_cfg         = stat_q.err_cfg;
    assign latency         = lat_q;

endmodule

// File: tb/tb_prbs_test_sequencer.sv
// Bench for prbs_test_sequencer: directed vector table, hand-written corner
// sequences, and randomized runs checked against an event-time model.
module tb_prbs_test_sequencer;

    localparam int TMO = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic [31:0] cfg_word = '0;
    logic [7:0]  cfg_n = '0;
    logic        abort = 1'b0;
    logic        pattern_detected = 1'b0;
    logic        prbs_data_valid, busy, done, pass, timed_out, aborted, err_cfg;
    logic [31:0] prbs_in;
    logic [7:0]  prbs_n;
    logic [15:0] latency;

    int n_cmp = 0;
    int n_bad = 0;

    prbs_test_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .start(start), .cfg_word(cfg_word), .cfg_n(cfg_n),
        .abort(abort), .prbs_data_valid(prbs_data_valid), .prbs_in(prbs_in),
        .prbs_n(prbs_n), .pattern_detected(pattern_detected), .busy(busy),
        .done(done), .pass(pass), .timed_out(timed_out), .aborted(aborted),
        .err_cfg(err_cfg), .latency(latency)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  n;
        int          det;     // RUN cycle of the detect pulse, -1 none
        int          abt;     // 0 = abort in LOAD, k = RUN cycle k, -1 none
        bit          second;  // extra start while busy
        bit          e_pass, e_to, e_ab, e_err;
        int          e_lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {prbs_data_valid, prbs_in, prbs_n, busy, done, pass, timed_out,
                aborted, err_cfg, latency};
    endfunction

    // Outcome from event times: earliest event wins, ties go abort > detect > timeout.
    task automatic model(input logic [7:0] n, input int det, input int abt,
                         output bit p, output bit t, output bit a, output bit e,
                         output int lat);
        int ta, td, tm;
        p = 0; t = 0; a = 0; e = 0; lat = 0;
        if (n == 0) begin
            e = 1;
        end else if (abt == 0) begin
            a = 1;
        end else begin
            ta = (abt > 0) ? abt : 1 << 30;
            td = (det > 0) ? det : 1 << 30;
            tm = ta;
            if (td < tm)  tm = td;
            if (TMO < tm) tm = TMO;
            lat = tm;
            if (ta == tm)      a = 1;
            else if (td == tm) p = 1;
            else               t = 1;
        end
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge just after DONE.
    task automatic do_run(input string nm, input vec_t v);
        int strobes = 0, dones = 0, done_j = -1;
        bit busy_seen = 0;
        logic [31:0] cap_w = '0;
        logic [7:0]  cap_n = '0;
        start = 1; cfg_word = v.word; cfg_n = v.n;
        for (int j = 1; j <= 200; j++) begin
            @(negedge CLK);
            if (prbs_data_valid) begin strobes++; cap_w = prbs_in; cap_n = prbs_n; end
            if (busy) busy_seen = 1;
            if (done) begin dones++; if (done_j < 0) done_j = j; end
            if (done_j >= 0 && j == done_j + 1) begin
                start = 0; abort = 0; pattern_detected = 0;
                break;
            end
            start = 0; cfg_word = $urandom; cfg_n = 8'($urandom);
            if (v.second && j == 3) begin start = 1; cfg_word = ~v.word; cfg_n = v.n + 8'd1; end
            pattern_detected = (v.det > 0 && j == v.det + 1);
            abort            = (v.abt >= 0 && j == v.abt + 1);
        end
        if (done_j < 0) begin
            start = 0; abort = 0; pattern_detected = 0;
            chk({nm, ".done_timeout"}, 64'd0, 64'd1);
            return;
        end
        chk({nm, ".done_cnt"}, dones, 1);
        chk({nm, ".done_cyc"}, done_j, v.e_err ? 1 : v.e_lat + 2);
        chk({nm, ".strobes"}, strobes, v.e_err ? 0 : 1);
        chk({nm, ".busy_seen"}, busy_seen, !v.e_err);
        if (!v.e_err) begin
            chk({nm, ".strobe_word"}, cap_w, v.word);
            chk({nm, ".strobe_n"}, cap_n, v.n);
            chk({nm, ".held_word"}, prbs_in, v.word);
            chk({nm, ".latency"}, latency, v.e_lat);
        end
        chk({nm, ".status"}, {pass, timed_out, aborted, err_cfg},
            {v.e_pass, v.e_to, v.e_ab, v.e_err});
    endtask

    vec_t tbl[11];
    vec_t rv;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            word          n      det abt 2nd  p  to ab er lat
        tbl[0]  = '{32'hAABBCCDD, 8'd4,   10, -1, 0,   1, 0, 0, 0, 10};
        tbl[1]  = '{32'h12345678, 8'd1,   -1, -1, 0,   0, 1, 0, 0, 16};
        tbl[2]  = '{32'hDEADBEEF, 8'd0,   -1, -1, 0,   0, 0, 0, 1, 0};
        tbl[3]  = '{32'h0F0F0F0F, 8'd9,   -1,  5, 0,   0, 0, 1, 0, 5};
        tbl[4]  = '{32'h11111111, 8'd2,    7,  7, 0,   0, 0, 1, 0, 7};
        tbl[5]  = '{32'h22222222, 8'd3,   16, -1, 0,   1, 0, 0, 0, 16};
        tbl[6]  = '{32'h33333333, 8'd5,    4,  0, 0,   0, 0, 1, 0, 0};
        tbl[7]  = '{32'h44444444, 8'd6,   -1, 16, 0,   0, 0, 1, 0, 16};
        tbl[8]  = '{32'h55555555, 8'd255,  1, -1, 0,   1, 0, 0, 0, 1};
        tbl[9]  = '{32'h66666666, 8'd7,    6, -1, 1,   1, 0, 0, 0, 6};
        tbl[10] = '{32'h77777777, 8'd8,   20, -1, 0,   0, 1, 0, 0, 16};

        repeat (2) @(negedge CLK);
        chk("reset_outs", all_outs(), 64'd0);
        RST = 0;
        @(negedge CLK);
        chk("post_reset_outs", all_outs(), 64'd0);

        foreach (tbl[i]) do_run($sformatf("vec%0d", i), tbl[i]);

        // Config error, then a start held into DONE must be ignored.
        start = 1; cfg_word = 32'hCAFEF00D; cfg_n = 0;
        @(negedge CLK);
        chk("cfgerr_done", done, 1);
        chk("cfgerr_nostrobe", {busy, prbs_data_valid}, 2'b00);
        cfg_n = 8'd5;
        @(negedge CLK);
        start = 0;
        chk("done_start_ignored", {busy, done, err_cfg}, 3'b001);
        // Detect while idle does nothing.
        pattern_detected = 1;
        repeat (3) @(negedge CLK);
        pattern_detected = 0;
        chk("idle_detect_ignored", {busy, done, pass, err_cfg}, 4'b0001);
        // Abort while idle does nothing.
        abort = 1;
        @(negedge CLK);
        abort = 0;
        chk("idle_abort_ignored", {done, aborted, err_cfg}, 3'b001);

        // Reset in the middle of RUN clears everything at once.
        start = 1; cfg_word = 32'hAABBCCDD; cfg_n = 4;
        @(negedge CLK); start = 0;
        repeat (3) @(negedge CLK);
        chk("midrun_busy", busy, 1);
        RST = 1;
        #1;
        chk("midrun_reset_outs", all_outs(), 64'd0);
        @(negedge CLK);
        RST = 0;
        @(negedge CLK);
        chk("after_reset_outs", all_outs(), 64'd0);
        do_run("rerun", tbl[0]);

        // Randomized runs against the event-time model.
        for (int r = 0; r < 40; r++) begin
            rv.word = $urandom;
            rv.n    = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            rv.det  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 20));
            rv.abt  = ($urandom_range(0, 3) != 0) ? -1 : int'($urandom_range(0, 20));
            rv.second = (rv.n != 0) && (rv.abt != 0) && ($urandom_range(0, 1) == 1);
            model(rv.n, rv.det, rv.abt, rv.e_pass, rv.e_to, rv.e_ab, rv.e_err, rv.e_lat);
            do_run($sformatf("rnd%0d", r), rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
